// File: rtl/ram_datos_dump_ctrl.sv
// Shares the single ram_datos port between the MEM stage (always first) and a
// debug memory dump that reads every word in idle cycles and streams it out.
module ram_datos_dump_ctrl #(
    parameter int RAM_WIDTH = 16,
    parameter int RAM_DEPTH = 1024,
    parameter int RD_LAT    = 1,
    parameter int BUF_DEPTH = 4,
    localparam int AW       = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
    input  logic                 clka,
    input  logic                 rsta_n,
    input  logic                 cpu_en,
    input  logic                 cpu_we,
    input  logic [AW-1:0]        cpu_addr,
    input  logic [RAM_WIDTH-1:0] cpu_din,
    output logic [RAM_WIDTH-1:0] cpu_dout,
    output logic [AW-1:0]        ram_addra,
    output logic [RAM_WIDTH-1:0] ram_dina,
    output logic                 ram_wea,
    output logic                 ram_ena,
    input  logic [RAM_WIDTH-1:0] ram_douta,
    input  logic                 dump_start,
    output logic                 dump_busy,
    output logic                 dump_done,
    output logic                 dump_valid,
    input  logic                 dump_ready,
    output logic [RAM_WIDTH-1:0] dump_data,
    output logic [AW-1:0]        dump_addr
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + RD_LAT) + 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(RAM_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN
    } state_t;

    state_t               state_q;
    logic [AW-1:0]        issueAddr_q;
    logic                 dumpBusy_q;
    logic                 dumpDone_q;

    logic                 issue;
    logic                 exitValid;
    logic [AW-1:0]        exitAddr;
    logic [CW-1:0]        inflight;

    logic [RAM_WIDTH-1:0] fifoData_q [BUF_DEPTH];
    logic [AW-1:0]        fifoAddr_q [BUF_DEPTH];
    logic [PW-1:0]        wrPtr_q;
    logic [PW-1:0]        rdPtr_q;
    logic [CW-1:0]        fifoCount_q;
    logic [CW-1:0]        fifoCount_d;
    logic                 push;
    logic                 pop;

    // Credit check: every read already in flight owns a FIFO slot, so a push can never overflow.
    assign issue = (state_q == SCAN) && !cpu_en &&
                   ((fifoCount_q + inflight) < CW'(BUF_DEPTH));

    always_comb begin
        ram_addra = issueAddr_q;
        ram_dina  = cpu_din;
        ram_wea   = 1'b0;
        ram_ena   = issue;
        if (cpu_en) begin
            ram_addra = cpu_addr;
            ram_wea   = cpu_we;
            ram_ena   = 1'b1;
        end
    end

    assign cpu_dout = ram_douta;

    // The issue cycle is the first latency stage, so only RD_LAT-1 tag registers are needed.
    if (RD_LAT == 1) begin : gNoPipe
        assign exitValid = issue;
        assign exitAddr  = issueAddr_q;
        assign inflight  = '0;
    end else begin : gPipe
        logic [RD_LAT-2:0] tagValid_q;
        logic [AW-1:0]     tagAddr_q [RD_LAT-1];

        always_ff @(posedge clka or negedge rsta_n) begin
            if (!rsta_n) begin
                tagValid_q <= '0;
                for (int k = 0; k < RD_LAT - 1; k++) begin
                    tagAddr_q[k] <= '0;
                end
            end else begin
                tagValid_q[0] <= issue;
                tagAddr_q[0]  <= issueAddr_q;
                for (int k = 1; k < RD_LAT - 1; k++) begin
                    tagValid_q[k] <= tagValid_q[k-1];
                    tagAddr_q[k]  <= tagAddr_q[k-1];
                end
            end
        end

        always_comb begin
            inflight = '0;
            for (int k = 0; k < RD_LAT - 1; k++) begin
                inflight = inflight + CW'(tagValid_q[k]);
            end
        end

        assign exitValid = tagValid_q[RD_LAT-2];
        assign exitAddr  = tagAddr_q[RD_LAT-2];
    end

    assign push        = exitValid;
    assign pop         = dump_valid && dump_ready;
    assign fifoCount_d = fifoCount_q + CW'(push) - CW'(pop);

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            fifoCount_q <= '0;
            for (int k = 0; k < BUF_DEPTH; k++) begin
                fifoData_q[k] <= '0;
                fifoAddr_q[k] <= '0;
            end
        end else begin
            if (push) begin
                fifoData_q[wrPtr_q] <= ram_douta;
                fifoAddr_q[wrPtr_q] <= exitAddr;
                wrPtr_q             <= wrPtr_q + PW'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + PW'(1);
            end
            fifoCount_q <= fifoCount_d;
        end
    end

    assign dump_valid = (fifoCount_q != '0);
    assign dump_data  = fifoData_q[rdPtr_q];
    assign dump_addr  = fifoAddr_q[rdPtr_q];

    // Leaving DRAIN uses the post-edge FIFO count so dump_done lands on the edge that accepts the last word.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            state_q     <= IDLE;
            issueAddr_q <= '0;
            dumpBusy_q  <= 1'b0;
            dumpDone_q  <= 1'b0;
        end else begin
            dumpDone_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (dump_start) begin
                        state_q     <= SCAN;
                        issueAddr_q <= '0;
                        dumpBusy_q  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (issue) begin
                        if (issueAddr_q == LAST_ADDR) begin
                            state_q <= DRAIN;
                        end else begin
                            issueAddr_q <= issueAddr_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if ((inflight == '0) && (fifoCount_d == '0)) begin
                        state_q    <= IDLE;
                        dumpBusy_q <= 1'b0;
                        dumpDone_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    dumpBusy_q <= 1'b0;
                end
            endcase
        end
    end

    assign dump_busy = dumpBusy_q;
    assign dump_done = dumpDone_q;

endmodule

// File: tb/tb_ram_datos_dump_ctrl.sv
// Bench for ram_datos_dump_ctrl: two instances (RD_LAT=1 and RD_LAT=2) share one
// stimulus stream, each with its own falling-edge RAM model and expected-beat queue.
module tb_ram_datos_dump_ctrl;

    localparam int DEPTH     = 16;
    localparam int BUF_DEPTH = 4;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
    } beat_t;

    typedef struct {
        logic        en;
        logic        we;
        logic [3:0]  addr;
        logic [15:0] din;
        logic        expEna;
        logic        expWea;
        logic        chkDout;
        logic [15:0] expDout;
    } vec_t;

    logic        clk;
    logic        rstN;
    logic        cpuEn;
    logic        cpuWe;
    logic [3:0]  cpuAddr;
    logic [15:0] cpuDin;
    logic        dumpStart;
    logic        dumpReady;
    logic        initReq;

    logic [15:0] cpuDout   [2];
    logic [15:0] ramDina   [2];
    logic [15:0] ramDouta  [2];
    logic [15:0] dumpData  [2];
    logic [3:0]  ramAddra  [2];
    logic [3:0]  dumpAddr  [2];
    logic [1:0]  ramWea;
    logic [1:0]  ramEna;
    logic [1:0]  dumpBusy;
    logic [1:0]  dumpDone;
    logic [1:0]  dumpValid;

    int          nCompared;
    int          nMismatched;
    int          cycleNo;
    int          beats     [2];
    int          issues    [2];
    int          doneCnt   [2];
    int          firstBeat [2];
    int          lastBeat  [2];
    int          doneCycle [2];
    logic        stalled   [2];
    logic [3:0]  heldAddr  [2];
    logic [15:0] heldData  [2];
    logic [15:0] shadow    [DEPTH];
    beat_t       expQ0[$];
    beat_t       expQ1[$];
    vec_t        vecs[6];

    ram_datos_dump_ctrl #(
        .RAM_WIDTH(16), .RAM_DEPTH(DEPTH), .RD_LAT(1), .BUF_DEPTH(BUF_DEPTH)
    ) u0 (
        .clka(clk), .rsta_n(rstN),
        .cpu_en(cpuEn), .cpu_we(cpuWe), .cpu_addr(cpuAddr), .cpu_din(cpuDin),
        .cpu_dout(cpuDout[0]),
        .ram_addra(ramAddra[0]), .ram_dina(ramDina[0]), .ram_wea(ramWea[0]),
        .ram_ena(ramEna[0]), .ram_douta(ramDouta[0]),
        .dump_start(dumpStart), .dump_busy(dumpBusy[0]), .dump_done(dumpDone[0]),
        .dump_valid(dumpValid[0]), .dump_ready(dumpReady),
        .dump_data(dumpData[0]), .dump_addr(dumpAddr[0])
    );

    ram_datos_dump_ctrl #(
        .RAM_WIDTH(16), .RAM_DEPTH(DEPTH), .RD_LAT(2), .BUF_DEPTH(BUF_DEPTH)
    ) u1 (
        .clka(clk), .rsta_n(rstN),
        .cpu_en(cpuEn), .cpu_we(cpuWe), .cpu_addr(cpuAddr), .cpu_din(cpuDin),
        .cpu_dout(cpuDout[1]),
        .ram_addra(ramAddra[1]), .ram_dina(ramDina[1]), .ram_wea(ramWea[1]),
        .ram_ena(ramEna[1]), .ram_douta(ramDouta[1]),
        .dump_start(dumpStart), .dump_busy(dumpBusy[1]), .dump_done(dumpDone[1]),
        .dump_valid(dumpValid[1]), .dump_ready(dumpReady),
        .dump_data(dumpData[1]), .dump_addr(dumpAddr[1])
    );

    // Read-first block RAM sampled on the falling edge; instance 1 adds an output register.
    for (genvar g = 0; g < 2; g++) begin : gRam
        logic [15:0] mem [DEPTH];
        logic [15:0] rdData;
        logic [15:0] rdReg;

        always @(negedge clk) begin
            if (initReq) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem[i] <= 16'(i);
                end
            end else if (ramEna[g]) begin
                if (ramWea[g]) begin
                    mem[ramAddra[g]] <= ramDina[g];
                end
                rdData <= mem[ramAddra[g]];
            end
            rdReg <= rdData;
        end

        assign ramDouta[g] = (g == 0) ? rdData : rdReg;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic we, input logic [3:0] addr,
                                 input logic [15:0] din, input logic start, input logic ready);
        cpuEn     = en;
        cpuWe     = we;
        cpuAddr   = addr;
        cpuDin    = din;
        dumpStart = start;
        dumpReady = ready;
    endtask

    function automatic bit popExp(input int k, output beat_t b);
        b = '{addr: 4'd0, data: 16'd0};
        if (k == 0) begin
            if (expQ0.size() == 0) return 1'b0;
            b = expQ0.pop_front();
        end else begin
            if (expQ1.size() == 0) return 1'b0;
            b = expQ1.pop_front();
        end
        return 1'b1;
    endfunction

    task automatic initRam();
        for (int i = 0; i < DEPTH; i++) begin
            shadow[i] = 16'(i);
        end
        initReq = 1'b1;
        @(posedge clk);
        #1;
        initReq = 1'b0;
    endtask

    task automatic pushExpected();
        for (int i = 0; i < DEPTH; i++) begin
            expQ0.push_back('{addr: 4'(i), data: shadow[i]});
            expQ1.push_back('{addr: 4'(i), data: shadow[i]});
        end
    endtask

    task automatic clearStats();
        for (int k = 0; k < 2; k++) begin
            beats[k]     = 0;
            issues[k]    = 0;
            doneCnt[k]   = 0;
            firstBeat[k] = -1;
            lastBeat[k]  = -1;
            doneCycle[k] = -1;
            stalled[k]   = 1'b0;
        end
    endtask

    // Called mid-cycle, after the RAM's falling edge and well before the next rising edge.
    task automatic sampleCycle();
        beat_t exp;
        for (int k = 0; k < 2; k++) begin
            if (ramEna[k] && !cpuEn) begin
                issues[k]++;
                checkOutput($sformatf("outstanding<=BUF_DEPTH u%0d", k),
                            32'(issues[k] - beats[k] <= BUF_DEPTH), 32'd1);
            end
            if (stalled[k] && dumpValid[k]) begin
                checkOutput($sformatf("stall addr stable u%0d", k), 32'(dumpAddr[k]), 32'(heldAddr[k]));
                checkOutput($sformatf("stall data stable u%0d", k), 32'(dumpData[k]), 32'(heldData[k]));
            end
            if (dumpValid[k] && dumpReady) begin
                if (!popExp(k, exp)) begin
                    nCompared++;
                    nMismatched++;
                    $display("[TB] FAIL extra beat u%0d: got addr 0x%0h, expected no beat", k, dumpAddr[k]);
                end else begin
                    checkOutput($sformatf("beat addr u%0d", k), 32'(dumpAddr[k]), 32'(exp.addr));
                    checkOutput($sformatf("beat data u%0d @%0d", k, exp.addr), 32'(dumpData[k]), 32'(exp.data));
                end
                if (beats[k] == 0) firstBeat[k] = cycleNo;
                lastBeat[k] = cycleNo;
                beats[k]++;
            end
            stalled[k]  = dumpValid[k] && !dumpReady;
            heldAddr[k] = dumpAddr[k];
            heldData[k] = dumpData[k];
            if (dumpDone[k]) begin
                doneCnt[k]++;
                doneCycle[k] = cycleNo;
                checkOutput($sformatf("busy low with done u%0d", k), 32'(dumpBusy[k]), 32'd0);
            end
        end
    endtask

    // mode 0 basic, 1 backpressure, 2 CPU priority, 3 ignored restart
    task automatic runDump(input int mode);
        logic        en;
        logic        we;
        logic [3:0]  addr;
        logic [15:0] din;
        logic        ready;
        logic [15:0] cpuExp0 [3];
        logic [15:0] cpuExp1 [2];
        bit          finished;
        cpuExp0  = '{16'h0002, 16'hBEEF, 16'h0000};
        cpuExp1  = '{16'h0002, 16'hBEEF};
        finished = 1'b0;
        initRam();
        if (mode == 2) shadow[12] = 16'hBEEF;
        pushExpected();
        clearStats();
        for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
            cycleNo = cyc;
            en = 1'b0; we = 1'b0; addr = 4'd0; din = 16'd0;
            if (mode == 2) begin
                case (cyc)
                    3: begin en = 1'b1; we = 1'b1; addr = 4'd12; din = 16'hBEEF; end
                    4: begin en = 1'b1; addr = 4'd2; end
                    5: begin en = 1'b1; addr = 4'd12; end
                    6: begin en = 1'b1; addr = 4'd0; end
                    default: ;
                endcase
            end
            ready = (mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            applyStimulus(en, we, addr, din, (cyc == 0) || (mode == 3 && cyc == 6), ready);
            #7;
            sampleCycle();
            if (mode == 2 && cyc >= 3 && cyc <= 6) begin
                for (int k = 0; k < 2; k++) begin
                    checkOutput($sformatf("cpu cyc%0d ram_ena u%0d", cyc, k), 32'(ramEna[k]), 32'd1);
                    checkOutput($sformatf("cpu cyc%0d ram_wea u%0d", cyc, k), 32'(ramWea[k]), 32'(we));
                    checkOutput($sformatf("cpu cyc%0d ram_addra u%0d", cyc, k), 32'(ramAddra[k]), 32'(addr));
                end
                if (cyc == 3) checkOutput("cpu write ram_dina", 32'(ramDina[0]), 32'hBEEF);
                if (cyc >= 4) checkOutput($sformatf("cpu_dout u0 cyc%0d", cyc), 32'(cpuDout[0]), 32'(cpuExp0[cyc-4]));
                if (cyc >= 5) checkOutput($sformatf("cpu_dout u1 cyc%0d", cyc), 32'(cpuDout[1]), 32'(cpuExp1[cyc-5]));
            end
            if (mode == 3 && cyc == 6) checkOutput("busy at ignored start", 32'(dumpBusy), 32'h3);
            if (doneCnt[0] > 0 && doneCnt[1] > 0 && cyc >= doneCycle[0] + 3 && cyc >= doneCycle[1] + 3)
                finished = 1'b1;
            @(posedge clk);
            #1;
        end
        applyStimulus(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("m%0d done count u%0d", mode, k), 32'(doneCnt[k]), 32'd1);
            checkOutput($sformatf("m%0d beat count u%0d", mode, k), 32'(beats[k]), 32'(DEPTH));
            checkOutput($sformatf("m%0d issue count u%0d", mode, k), 32'(issues[k]), 32'(DEPTH));
            checkOutput($sformatf("m%0d done after last beat u%0d", mode, k), 32'(doneCycle[k]), 32'(lastBeat[k] + 1));
            if (mode == 0) begin
                checkOutput($sformatf("first beat latency u%0d", k), 32'(firstBeat[k]), 32'(k + 2));
                checkOutput($sformatf("beats contiguous u%0d", k), 32'(lastBeat[k] - firstBeat[k]), 32'(DEPTH - 1));
            end
        end
        checkOutput($sformatf("m%0d leftover expected", mode), 32'(expQ0.size() + expQ1.size()), 32'd0);
        expQ0.delete();
        expQ1.delete();
    endtask

    initial begin
        vecs[0] = '{en: 1, we: 0, addr: 4'd5,  din: 16'h0000, expEna: 1, expWea: 0, chkDout: 1, expDout: 16'h0005};
        vecs[1] = '{en: 1, we: 1, addr: 4'd7,  din: 16'hAAAA, expEna: 1, expWea: 1, chkDout: 0, expDout: 16'h0000};
        vecs[2] = '{en: 1, we: 0, addr: 4'd7,  din: 16'h5555, expEna: 1, expWea: 0, chkDout: 1, expDout: 16'hAAAA};
        vecs[3] = '{en: 0, we: 0, addr: 4'd9,  din: 16'h0000, expEna: 0, expWea: 0, chkDout: 0, expDout: 16'h0000};
        vecs[4] = '{en: 1, we: 0, addr: 4'd15, din: 16'h0000, expEna: 1, expWea: 0, chkDout: 1, expDout: 16'h000F};
        vecs[5] = '{en: 0, we: 1, addr: 4'd3,  din: 16'h1234, expEna: 0, expWea: 0, chkDout: 0, expDout: 16'h0000};

        nCompared   = 0;
        nMismatched = 0;
        cycleNo     = 0;
        initReq     = 1'b0;
        rstN        = 1'b0;
        clearStats();
        applyStimulus(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b1);

        repeat (2) @(posedge clk);
        #1;
        #7;
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("reset busy u%0d", k),  32'(dumpBusy[k]),  32'd0);
            checkOutput($sformatf("reset done u%0d", k),  32'(dumpDone[k]),  32'd0);
            checkOutput($sformatf("reset valid u%0d", k), 32'(dumpValid[k]), 32'd0);
            checkOutput($sformatf("reset data u%0d", k),  32'(dumpData[k]),  32'd0);
            checkOutput($sformatf("reset addr u%0d", k),  32'(dumpAddr[k]),  32'd0);
        end
        @(posedge clk);
        #1;
        rstN = 1'b1;
        initRam();

        $display("[TB] idle RAM port mux vectors");
        for (int v = 0; v < 6; v++) begin
            applyStimulus(vecs[v].en, vecs[v].we, vecs[v].addr, vecs[v].din, 1'b0, 1'b1);
            #7;
            for (int k = 0; k < 2; k++) begin
                checkOutput($sformatf("vec%0d ram_ena u%0d", v, k), 32'(ramEna[k]), 32'(vecs[v].expEna));
                checkOutput($sformatf("vec%0d ram_wea u%0d", v, k), 32'(ramWea[k]), 32'(vecs[v].expWea));
                if (vecs[v].en) begin
                    checkOutput($sformatf("vec%0d ram_addra u%0d", v, k), 32'(ramAddra[k]), 32'(vecs[v].addr));
                end
                if (vecs[v].en && vecs[v].we) begin
                    checkOutput($sformatf("vec%0d ram_dina u%0d", v, k), 32'(ramDina[k]), 32'(vecs[v].din));
                end
            end
            if (vecs[v].chkDout) begin
                checkOutput($sformatf("vec%0d cpu_dout", v), 32'(cpuDout[0]), 32'(vecs[v].expDout));
            end
            @(posedge clk);
            #1;
        end
        applyStimulus(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b1);

        $display("[TB] basic dump");
        runDump(0);
        $display("[TB] backpressure dump");
        runDump(1);
        $display("[TB] CPU priority dump");
        runDump(2);
        $display("[TB] ignored restart dump");
        runDump(3);

        $display("[TB] reset mid-dump");
        initRam();
        pushExpected();
        clearStats();
        for (int cyc = 0; cyc < 60 && beats[0] < 5; cyc++) begin
            cycleNo = cyc;
            applyStimulus(1'b0, 1'b0, 4'd0, 16'd0, cyc == 0, 1'b1);
            #7;
            sampleCycle();
            @(posedge clk);
            #1;
        end
        checkOutput("words before reset u0", 32'(beats[0]), 32'd5);
        #2;
        rstN = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("async reset valid u%0d", k), 32'(dumpValid[k]), 32'd0);
            checkOutput($sformatf("async reset busy u%0d", k),  32'(dumpBusy[k]),  32'd0);
            checkOutput($sformatf("async reset addr u%0d", k),  32'(dumpAddr[k]),  32'd0);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #8;
            checkOutput($sformatf("no done in reset c%0d", c), 32'(dumpDone), 32'd0);
        end
        checkOutput("no done before reset", 32'(doneCnt[0] + doneCnt[1]), 32'd0);
        expQ0.delete();
        expQ1.delete();
        @(posedge clk);
        #1;
        rstN = 1'b1;

        $display("[TB] fresh dump after reset");
        runDump(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
